// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Sequencer that drives an external 8-bit ALU around an 8-bit accumulator.
// A command either loads the accumulator directly or runs one ALU operation,
// optionally repeated. Each pass holds the ALU operands for SETTLE_CYC cycles
// and then captures the ALU result, zero flag and carry-out. The result is
// presented on a valid/ready response port until it is consumed.
//
// Parameters
//   ACC_INIT    accumulator reset value
//   SETTLE_CYC  cycles the ALU operands are held before capture (1..3)
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready               command handshake (ready only in IDLE)
//   cmd_load, cmd_sel, cmd_cin,
//   cmd_b, cmd_rep                      command payload
//   alu_a, alu_b, alu_s, alu_cin        operands and controls to the ALU
//   alu_d, alu_z, alu_cout              result and flags from the ALU
//   rsp_valid / rsp_ready               response handshake (valid only in DONE)
//   rsp_acc, rsp_z, rsp_c               accumulator and flags, always visible
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter logic [7:0] ACC_INIT   = 8'h00,
  parameter int         SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_sel,
  input  logic       cmd_cin,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_rep,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_cin,
  input  logic [7:0] alu_d,
  input  logic       alu_z,
  input  logic       alu_cout,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_acc,
  output logic       rsp_z,
  output logic       rsp_c
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // The settle counter counts down to zero, so a pass spends exactly
  // SETTLE_CYC cycles in ISSUE.
  localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYC - 1);

  state_e     state_q, state_d;

  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [2:0] rep_cnt_q, rep_cnt_d;
  logic [1:0] settle_q, settle_d;

  // The ALU operand registers double as the command registers for b, sel and
  // cin; they are only written on acceptance or between passes, so they keep
  // their last values while the block is idle or waiting in DONE.
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] alu_s_q, alu_s_d;
  logic       alu_cin_q, alu_cin_d;

  logic       accept;
  assign accept = cmd_valid && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_load ? DONE : ISSUE;
      ISSUE:   if (settle_q == 2'd0) state_d = CAPTURE;
      CAPTURE: state_d = (rep_cnt_q != 3'd0) ? ISSUE : DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: pure decodes of the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    rep_cnt_d = rep_cnt_q;
    settle_d  = settle_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_s_d   = alu_s_q;
    alu_cin_d = alu_cin_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_load) begin
            acc_d = cmd_b;
            z_d   = (cmd_b == 8'h00);
            c_d   = 1'b0;
          end else begin
            // sel is copied verbatim; the block never interprets it.
            alu_a_d   = acc_q;
            alu_b_d   = cmd_b;
            alu_s_d   = cmd_sel;
            alu_cin_d = cmd_cin;
            rep_cnt_d = cmd_rep;
            settle_d  = SETTLE_INIT;
          end
        end
      end
      ISSUE: begin
        if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
      end
      CAPTURE: begin
        acc_d = alu_d;
        z_d   = alu_z;
        c_d   = alu_cout;
        if (rep_cnt_q != 3'd0) begin
          rep_cnt_d = rep_cnt_q - 3'd1;
          // Next pass operates on the freshly captured accumulator.
          alu_a_d   = alu_d;
          settle_d  = SETTLE_INIT;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= ACC_INIT;
      z_q       <= (ACC_INIT == 8'h00);
      c_q       <= 1'b0;
      rep_cnt_q <= 3'd0;
      settle_q  <= 2'd0;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_s_q   <= 4'h0;
      alu_cin_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      z_q       <= z_d;
      c_q       <= c_d;
      rep_cnt_q <= rep_cnt_d;
      settle_q  <= settle_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_s_q   <= alu_s_d;
      alu_cin_q <= alu_cin_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_s   = alu_s_q;
  assign alu_cin = alu_cin_q;

  assign rsp_acc = acc_q;
  assign rsp_z   = z_q;
  assign rsp_c   = c_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The parameter ACC_INIT, default 8'h00, SHALL set the accumulator reset value.
REQ-002 The parameter SETTLE_CYC, default 1, SHALL set the number of cycles ALU inputs are held before capture; the legal range is 1..3.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-004 Command ports:
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_load  in  1  1 = load cmd_b into the accumulator (no ALU op)
- cmd_sel  in  4  ALU select S[3:0]
- cmd_cin  in  1  ALU carry-in
- cmd_b  in  8  B operand, or the load value
- cmd_rep  in  3  number of extra repetitions (0 = execute once)
REQ-005 ALU ports:
- alu_a  out  8  ALU A operand
- alu_b  out  8  ALU B operand
- alu_s  out  4  ALU select
- alu_cin  out  1  ALU carry-in
- alu_d  in  8  ALU result D
- alu_z  in  1  ALU zero flag
- alu_cout  in  1  ALU carry-out
REQ-006 Response ports:
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_acc  out  8  accumulator value
- rsp_z  out  1  zero flag
- rsp_c  out  1  carry flag

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE and DONE.
REQ-008 cmd_ready SHALL be 1 only in IDLE, and SHALL be a decode of the state register only.
REQ-009 On acceptance with cmd_load=1, the next state SHALL be DONE, with acc=cmd_b, z=(cmd_b==0) and c=0.
REQ-010 On acceptance with cmd_load=0, the block SHALL register cmd_sel, cmd_cin, cmd_b and cmd_rep, load rep_cnt=cmd_rep, and go to ISSUE.
REQ-011 In ISSUE and CAPTURE, alu_a, alu_b, alu_s and alu_cin SHALL be driven from registers holding acc, b, sel and cin respectively.
REQ-012 ISSUE SHALL last exactly SETTLE_CYC cycles and then go to CAPTURE.
REQ-013 CAPTURE SHALL last one cycle. At its closing edge, acc<=alu_d, z<=alu_z and c<=alu_cout.
REQ-014 From CAPTURE, if rep_cnt!=0, the block SHALL decrement rep_cnt and go to ISSUE. In that ISSUE, alu_a SHALL equal the new acc.
REQ-015 From CAPTURE, if rep_cnt==0, the next state SHALL be DONE.
REQ-016 Latency: rsp_valid SHALL rise (cmd_rep+1)*(SETTLE_CYC+1) cycles after the acceptance edge for an ALU command, and 1 cycle after it for a load.
REQ-017 In DONE, rsp_valid SHALL be 1. rsp_acc, rsp_z and rsp_c SHALL hold stable until rsp_valid & rsp_ready.
REQ-018 On rsp_ready, the next state SHALL be IDLE. cmd_ready SHALL remain 0 in that same cycle; there is no same-cycle turnaround.
REQ-019 rsp_acc, rsp_z and rsp_c SHALL always reflect the acc, z and c registers, including outside DONE.
REQ-020 cmd_sel values containing x/z SHALL be passed to alu_s unmodified. The block SHALL NOT decode sel.
REQ-021 Outside ISSUE and CAPTURE, the ALU output ports SHALL hold their last values. ALU inputs SHALL be ignored outside CAPTURE.
REQ-022 Arithmetic SHALL be done only by the external ALU. The accumulator SHALL be exactly 8 bits wide, and wrap-around is whatever alu_d returns.

Reset
REQ-023 When rst_n=0, the following SHALL be set immediately (asynchronously):
- state=IDLE, acc=ACC_INIT, z=(ACC_INIT==0), c=0, rep_cnt=0
- alu_a, alu_b, alu_s and alu_cin = 0
- rsp_valid=0
REQ-024 A reset asserted in any state SHALL abort the command in progress without a response. After release, the first rising edge SHALL see cmd_ready=1.

Verification
REQ-025 Load then add:
- Load 43, then issue sel=0000, cin=0, b=17 with a reference ALU attached.
- Required: acc=60, z=0, c=0, and rsp_valid 2 cycles after acceptance (SETTLE_CYC=1).
REQ-026 Subtract by complement:
- With acc=43, issue sel=0001, cin=1, b=17.
- Required: acc=26, c=1, z=0.
REQ-027 Repeat:
- With acc=43, issue sel=0010, cin=1, rep=3.
- Required: acc=47 after 4 ALU passes, and rsp_valid at acceptance+8 cycles.
- alu_a SHALL step through 43, 44, 45, 46.
REQ-028 Zero load:
- Load 0.
- Required: rsp_z=1, rsp_c=0, and rsp_valid 1 cycle after acceptance.
REQ-029 Backpressure:
- Hold rsp_ready=0 for 5 cycles in DONE while cmd_valid=1.
- Required: rsp_* stable and cmd_ready=0 throughout. After the rsp_ready pulse, cmd_ready=1 on the following cycle.
REQ-030 Reset mid-operation:
- Drop rst_n during ISSUE of a rep=7 command.
- Required: immediately acc=ACC_INIT, alu_s=0 and rsp_valid=0, with no response produced.
